// File: rtl/uart_top.sv
// uart_top: 8-bit bus UART with TX/RX FIFOs, 16-bit bit-period divider, W1C error flags.
// Define UART_PARITY_EN for an even parity bit (8E1); the default build is 8N1.
module uart_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_top #(
    parameter int          ADDR_LSB          = 0,
    parameter int          OPT_MEM_ADDR_BITS = 1,
    parameter int          FIFO_AW           = 2,
    parameter logic [15:0] BAUD_DIV_RESET    = 16'd867
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic       txd,
    input  logic       rxd,
    output logic       irq
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    localparam logic [OPT_MEM_ADDR_BITS:0] R_DATA = 0;
    localparam logic [OPT_MEM_ADDR_BITS:0] R_STAT = 1;
    localparam logic [OPT_MEM_ADDR_BITS:0] R_BLO  = 2;
    localparam logic [OPT_MEM_ADDR_BITS:0] R_BHI  = 3;

    logic [OPT_MEM_ADDR_BITS:0] sel;
    logic [15:0] div;
    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_head;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  rx_head;
    state_t      tx_state, rx_state;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, rx_sh;
    logic        rx_s1, rx_s2, rx_d;
    logic        overrun, frame_err, parity_err;
    logic        stop_at, ovr_set, frm_set, par_set, stat_wr;
    logic [7:0]  status;

    assign sel     = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
    assign stat_wr = wr_en && (sel == R_STAT);
    assign tx_push = wr_en && (sel == R_DATA);
    assign rx_pop  = rd_en && (sel == R_DATA);
    assign tx_pop  = !tx_empty && ((tx_state == S_IDLE) ||
                     (tx_state == S_STOP && tx_cnt == '0));
    assign stop_at = (rx_state == S_STOP) && (rx_cnt == '0);
    assign rx_push = stop_at && rx_s2;
    assign frm_set = stop_at && !rx_s2;
    assign ovr_set = rx_push && rx_full && !rx_pop;

    uart_fifo #(.AW(FIFO_AW)) u_txf (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .wdata(din), .rdata(tx_head), .empty(tx_empty), .full(tx_full)
    );

    uart_fifo #(.AW(FIFO_AW)) u_rxf (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
        .wdata(rx_sh), .rdata(rx_head), .empty(rx_empty), .full(rx_full)
    );

    assign status = {parity_err, tx_state != S_IDLE, frame_err, overrun,
                     rx_full, !rx_empty, tx_empty, tx_full};

    always_comb begin
        dout = 8'h00;
        case (sel)
            R_DATA:  dout = rx_empty ? 8'h00 : rx_head;
            R_STAT:  dout = status;
            R_BLO:   dout = div[7:0];
            R_BHI:   dout = div[15:8];
            default: dout = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= BAUD_DIV_RESET;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_en && sel == R_BLO) div[7:0]  <= din;
            if (wr_en && sel == R_BHI) div[15:8] <= din;
            overrun   <= ovr_set | (overrun & ~(stat_wr & din[4]));
            frame_err <= frm_set | (frame_err & ~(stat_wr & din[5]));
            irq       <= !rx_empty | overrun | frame_err | parity_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            txd      <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            case (tx_state)
                S_IDLE: if (tx_pop) begin
                    tx_state <= S_START;
                    txd      <= 1'b0;
                    tx_cnt   <= div;
                    tx_sh    <= tx_head;
                end
                S_START: if (tx_cnt == '0) begin
                    tx_state <= S_DATA;
                    txd      <= tx_sh[0];
                    tx_cnt   <= div;
                    tx_bit   <= '0;
                end else tx_cnt <= tx_cnt - 1'b1;
                S_DATA: if (tx_cnt == '0) begin
                    tx_cnt <= div;
                    if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state <= S_PAR;
                        txd      <= ^tx_sh;
`else
                        tx_state <= S_STOP;
                        txd      <= 1'b1;
`endif
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                        txd    <= tx_sh[tx_bit + 3'd1];
                    end
                end else tx_cnt <= tx_cnt - 1'b1;
                S_PAR: if (tx_cnt == '0) begin
                    tx_state <= S_STOP;
                    txd      <= 1'b1;
                    tx_cnt   <= div;
                end else tx_cnt <= tx_cnt - 1'b1;
                S_STOP: if (tx_cnt == '0) begin
                    // Chain straight into the next start bit when data waits.
                    if (tx_pop) begin
                        tx_state <= S_START;
                        txd      <= 1'b0;
                        tx_cnt   <= div;
                        tx_sh    <= tx_head;
                    end else tx_state <= S_IDLE;
                end else tx_cnt <= tx_cnt - 1'b1;
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            case (rx_state)
                S_IDLE: if (!rx_s2 && rx_d) begin
                    rx_state <= S_START;
                    rx_cnt   <= div >> 1;
                end
                S_START: if (rx_cnt == '0) begin
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    rx_cnt   <= div;
                    rx_bit   <= '0;
                end else rx_cnt <= rx_cnt - 1'b1;
                S_DATA: if (rx_cnt == '0) begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_cnt <= div;
                    rx_bit <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
                    if (rx_bit == 3'd7) rx_state <= S_PAR;
`else
                    if (rx_bit == 3'd7) rx_state <= S_STOP;
`endif
                end else rx_cnt <= rx_cnt - 1'b1;
                S_PAR: if (rx_cnt == '0) begin
                    rx_state <= S_STOP;
                    rx_cnt   <= div;
                end else rx_cnt <= rx_cnt - 1'b1;
                // Leave at the mid-stop sample so a fast sender is not missed.
                S_STOP: if (rx_cnt == '0) rx_state <= S_IDLE;
                        else rx_cnt <= rx_cnt - 1'b1;
                default: rx_state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_PARITY_EN
    logic par_bad;
    assign par_set = rx_push && par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (rx_state == S_PAR && rx_cnt == '0) par_bad <= rx_s2 ^ (^rx_sh);
            parity_err <= par_set | (parity_err & ~(stat_wr & din[7]));
        end
    end
`else
    assign par_set    = 1'b0;
    assign parity_err = par_set;
`endif
endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top in its default 8N1 build at divider 3.
module tb_uart_top;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       txd;
    logic       rxd;
    logic       irq;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;
    int         checks = 0;
    int         errors = 0;

    assign rxd = loop ? txd : rx_drv;

    always #5 clk = ~clk;

    uart_top dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .dout(dout),
        .wr_en(wr_en), .rd_en(rd_en), .txd(txd), .rxd(rxd), .irq(irq)
    );

    function automatic logic fbit(input logic [7:0] b, input int sym);
        if (sym == 0) return 1'b0;
        if (sym == 9) return 1'b1;
        return b[sym-1];
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        din = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        #1 d = dout;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        rd_en = 1'b1;
        #1 d = dout;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        for (int s = 0; s < 10; s++) begin
            rx_drv = (s == 9) ? stop : fbit(b, s);
            repeat (4) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] v;
        logic [7:0] exp_r [4];
        exp_r = '{8'h00, 8'h02, 8'h63, 8'h03};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 4; r++) begin
            peek(8'(r), v);
            checks++;
            if (v !== exp_r[r]) begin
                errors++;
                $display("FAIL reset_reg%0d got %h want %h", r, v, exp_r[r]);
            end
        end
        checks++;
        if (txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd got %b want 1", txd);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
    endtask

    task automatic test_tx_single;
        logic [7:0] v;
        wr(8'h02, 8'h03);
        wr(8'h03, 8'h00);
        peek(8'h02, v);
        checks++;
        if (v !== 8'h03) begin
            errors++;
            $display("FAIL baud_lo got %h want 03", v);
        end
        wr(8'h00, 8'hA5);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (txd !== fbit(8'hA5, k / 4)) begin
                errors++;
                $display("FAIL tx_a5 cycle %0d got %b want %b", k, txd, fbit(8'hA5, k / 4));
            end
        end
        peek(8'h01, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL tx_a5_idle status got %h want 02", v);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] v;
        fork
            begin
                @(negedge clk);
                addr = 8'h00;
                wr_en = 1'b1;
                din = 8'h01;
                for (int i = 2; i <= 5; i++) begin
                    @(negedge clk);
                    din = 8'(i);
                end
                @(negedge clk);
                wr_en = 1'b0;
                addr = 8'h01;
                #1;
                checks++;
                if (dout !== 8'h41) begin
                    errors++;
                    $display("FAIL b2b_full status got %h want 41", dout);
                end
            end
            begin
                int w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (txd !== 1'b0 && w < 20);
                checks++;
                if (txd !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_start got %b want 0 within 20 cycles", txd);
                end else begin
                    for (int s = 0; s < 200; s++) begin
                        if (s > 0) @(negedge clk);
                        checks++;
                        if (txd !== fbit(8'(s / 40 + 1), (s % 40) / 4)) begin
                            errors++;
                            $display("FAIL b2b_stream sample %0d got %b want %b", s, txd,
                                     fbit(8'(s / 40 + 1), (s % 40) / 4));
                        end
                    end
                end
            end
        join
        peek(8'h01, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL b2b_idle status got %h want 02", v);
        end
    endtask

    task automatic test_loopback;
        logic [7:0] v;
        int w;
        loop = 1'b1;
        wr(8'h00, 8'h3C);
        w = 0;
        do begin
            peek(8'h01, v);
            w++;
        end while (v[2] !== 1'b1 && w < 200);
        checks++;
        if (v[2] !== 1'b1 || v[5:4] !== 2'b00) begin
            errors++;
            $display("FAIL loop_rx_valid status got %h want b2=1 b5:4=0", v);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL loop_irq_set got %b want 1", irq);
        end
        rd(8'h00, v);
        checks++;
        if (v !== 8'h3C) begin
            errors++;
            $display("FAIL loop_data got %h want 3c", v);
        end
        peek(8'h01, v);
        checks++;
        if (v[2] !== 1'b0) begin
            errors++;
            $display("FAIL loop_rx_drained status got %h want b2=0", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL loop_irq_clr got %b want 0", irq);
        end
        repeat (40) @(negedge clk);
        loop = 1'b0;
    endtask

    task automatic test_overrun;
        logic [7:0] v;
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1);
        peek(8'h01, v);
        checks++;
        if (v !== 8'h1E) begin
            errors++;
            $display("FAIL ovr_status got %h want 1e", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL ovr_irq got %b want 1", irq);
        end
        wr(8'h01, 8'h10);
        peek(8'h01, v);
        checks++;
        if (v !== 8'h0E) begin
            errors++;
            $display("FAIL ovr_w1c status got %h want 0e", v);
        end
        for (int i = 0; i < 4; i++) begin
            rd(8'h00, v);
            checks++;
            if (v !== bytes[i]) begin
                errors++;
                $display("FAIL ovr_byte%0d got %h want %h", i, v, bytes[i]);
            end
        end
        peek(8'h01, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL ovr_drained status got %h want 02", v);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL ovr_irq_clr got %b want 0", irq);
        end
    endtask

    task automatic test_frame_err;
        logic [7:0] v;
        send_frame(8'h5A, 1'b0);
        peek(8'h01, v);
        checks++;
        if (v !== 8'h22) begin
            errors++;
            $display("FAIL frm_status got %h want 22", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL frm_irq got %b want 1", irq);
        end
        wr(8'h01, 8'h20);
        peek(8'h01, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL frm_w1c status got %h want 02", v);
        end
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        peek(8'h01, v);
        checks++;
        if (v !== 8'h02) begin
            errors++;
            $display("FAIL glitch status got %h want 02", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL glitch_irq got %b want 0", irq);
        end
    endtask

    initial begin
        test_reset;
        test_tx_single;
        test_back_to_back;
        test_loopback;
        test_overrun;
        test_frame_err;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
